bldc_gate_supervisor: RTL and testbench

BLDC_GATE_SUPERVISOR -- requirements
Module: bldc_gate_supervisor

---
 rtl/bldc_gate_supervisor.sv | 189 ++++++++++++++++++
 tb/tb_bldc_gate_supervisor.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bldc_gate_supervisor.sv
// BLDC gate-driver supervisor.
// Sequences bootstrap precharge, run, fault handling, cooldown and lockout.
// Driver fault and overcurrent inputs are synchronized before use.
// Overcurrent must persist for OC_FILTER samples before it counts.
// Every output is a register driven from the next state.
module bldc_gate_supervisor #(
    parameter int PRECHARGE_CYCLES = 5400,
    parameter int COOLDOWN_CYCLES  = 540000,
    parameter int MAX_RETRIES      = 3,
    parameter int OC_FILTER        = 4
) (
    input  logic                               pclk,
    input  logic                               prst,
    input  logic                               enable_req,
    input  logic                               clear_lockout,
    input  logic                               fault_n,
    input  logic                               overcurrent_n,
    output logic                               gate_enable,
    output logic                               precharge,
    output logic                               pwm_allow,
    output logic [2:0]                         state,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
    output logic                               lockout,
    output logic [1:0]                         fault_cause
);

    // One timer serves precharge, cooldown and clean-run measurement,
    // so it is sized for the longer of the two durations.
    localparam int TMR_MAX = (PRECHARGE_CYCLES > COOLDOWN_CYCLES) ? PRECHARGE_CYCLES : COOLDOWN_CYCLES;
    localparam int TW      = $clog2(TMR_MAX + 1);
    localparam int RW      = $clog2(MAX_RETRIES + 1);
    localparam int OW      = $clog2(OC_FILTER + 1);

    localparam logic [TW-1:0] PRE_LAST    = TW'(PRECHARGE_CYCLES - 1);
    localparam logic [TW-1:0] COOL_LAST   = TW'(COOLDOWN_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);
    localparam logic [OW-1:0] OC_QUAL_CNT = OW'(OC_FILTER - 1);
    localparam logic [OW-1:0] OC_SAT      = OW'(OC_FILTER);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_PRECHARGE = 3'd1;
    localparam logic [2:0] ST_RUN       = 3'd2;
    localparam logic [2:0] ST_FAULT     = 3'd3;
    localparam logic [2:0] ST_COOLDOWN  = 3'd4;
    localparam logic [2:0] ST_LOCKOUT   = 3'd5;

    logic [1:0]    fault_sync;
    logic [1:0]    oc_sync;
    logic [OW-1:0] oc_cnt;
    logic [TW-1:0] timer;
    logic [TW-1:0] next_timer;
    logic [2:0]    next_state;
    logic          fault_qual;
    logic          oc_qual;
    logic          any_fault;

    // Two-flop synchronizers; idle level is high (inactive).
    always_ff @(posedge pclk) begin
        if (prst) begin
            fault_sync <= 2'b11;
            oc_sync    <= 2'b11;
        end else begin
            fault_sync <= {fault_sync[0], fault_n};
            oc_sync    <= {oc_sync[0], overcurrent_n};
        end
    end

    // Counts earlier consecutive low overcurrent samples, saturating.
    always_ff @(posedge pclk) begin
        if (prst) begin
            oc_cnt <= '0;
        end else if (oc_sync[1]) begin
            oc_cnt <= '0;
        end else if (oc_cnt != OC_SAT) begin
            oc_cnt <= oc_cnt + OW'(1);
        end
    end

    // The current low sample qualifies once the earlier low samples
    // plus this one reach OC_FILTER.
    assign fault_qual = ~fault_sync[1];
    assign oc_qual    = ~oc_sync[1] && (oc_cnt >= OC_QUAL_CNT);
    assign any_fault  = fault_qual | oc_qual;

    // Next-state and timer selection; faults outrank enable_req in active states.
    always_comb begin
        next_state = state;
        next_timer = timer;
        case (state)
            ST_IDLE: begin
                next_timer = '0;
                if (enable_req && !any_fault) begin
                    next_state = ST_PRECHARGE;
                end
            end
            ST_PRECHARGE: begin
                if (any_fault) begin
                    next_state = ST_FAULT;
                    next_timer = '0;
                end else if (!enable_req) begin
                    next_state = ST_IDLE;
                    next_timer = '0;
                end else if (timer == PRE_LAST) begin
                    next_state = ST_RUN;
                    next_timer = '0;
                end else begin
                    next_timer = timer + TW'(1);
                end
            end
            ST_RUN: begin
                if (any_fault) begin
                    next_state = ST_FAULT;
                    next_timer = '0;
                end else if (!enable_req) begin
                    next_state = ST_IDLE;
                    next_timer = '0;
                end else if (timer != COOL_LAST) begin
                    next_timer = timer + TW'(1);
                end
            end
            ST_FAULT: begin
                next_timer = '0;
                if (retry_count == RETRY_MAX) begin
                    next_state = ST_LOCKOUT;
                end else begin
                    next_state = ST_COOLDOWN;
                end
            end
            ST_COOLDOWN: begin
                if (timer == COOL_LAST) begin
                    next_timer = '0;
                    if (!enable_req) begin
                        next_state = ST_IDLE;
                    end else if (!any_fault) begin
                        next_state = ST_PRECHARGE;
                    end
                end else begin
                    next_timer = timer + TW'(1);
                end
            end
            ST_LOCKOUT: begin
                next_timer = '0;
                if (clear_lockout) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
                next_timer = '0;
            end
        endcase
    end

    // State, timer and registered outputs, all following the next state.
    always_ff @(posedge pclk) begin
        if (prst) begin
            state       <= ST_IDLE;
            timer       <= '0;
            gate_enable <= 1'b0;
            precharge   <= 1'b0;
            pwm_allow   <= 1'b0;
            retry_count <= '0;
            lockout     <= 1'b0;
            fault_cause <= 2'b00;
        end else begin
            state       <= next_state;
            timer       <= next_timer;
            gate_enable <= (next_state == ST_PRECHARGE) || (next_state == ST_RUN);
            precharge   <= (next_state == ST_PRECHARGE);
            pwm_allow   <= (next_state == ST_RUN);
            lockout     <= (next_state == ST_LOCKOUT);

            if (state == ST_LOCKOUT && clear_lockout) begin
                retry_count <= '0;
            end else if (state == ST_FAULT && retry_count != RETRY_MAX) begin
                retry_count <= retry_count + RW'(1);
            end else if (state == ST_RUN && timer == COOL_LAST) begin
                retry_count <= '0;
            end

            if (next_state == ST_FAULT) begin
                fault_cause <= fault_cause | {oc_qual, fault_qual};
            end else if (clear_lockout) begin
                fault_cause <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_bldc_gate_supervisor.sv
// Testbench for bldc_gate_supervisor.
// Directed scenarios with literal expectations, followed by randomized traffic.
// The randomized traffic is compared against a cycle model kept in this bench.
module tb_bldc_gate_supervisor;

    localparam int P  = 8;
    localparam int C  = 16;
    localparam int MR = 2;
    localparam int F  = 3;
    localparam int RW = $clog2(MR + 1);

    localparam int IDLE = 0, PRE = 1, RUN = 2, FLT = 3, COOL = 4, LOCK = 5;

    logic          pclk = 1'b0;
    logic          prst = 1'b1;
    logic          enable_req = 1'b0;
    logic          clear_lockout = 1'b0;
    logic          fault_n = 1'b1;
    logic          overcurrent_n = 1'b1;
    logic          gate_enable;
    logic          precharge;
    logic          pwm_allow;
    logic [2:0]    state;
    logic [RW-1:0] retry_count;
    logic          lockout;
    logic [1:0]    fault_cause;

    int vectors     = 0;
    int miscompares = 0;
    bit checking    = 1'b0;

    // Model state: the current mode, how long it has lasted, and the
    // input samples still travelling through the synchronizers.
    int m_state  = IDLE;
    int m_age    = 0;
    int m_retry  = 0;
    int m_cause  = 0;
    int m_streak = 0;
    bit f_pipe[$] = '{1'b1, 1'b1};
    bit o_pipe[$] = '{1'b1, 1'b1};

    bldc_gate_supervisor #(
        .PRECHARGE_CYCLES(P),
        .COOLDOWN_CYCLES (C),
        .MAX_RETRIES     (MR),
        .OC_FILTER       (F)
    ) dut (
        .pclk         (pclk),
        .prst         (prst),
        .enable_req   (enable_req),
        .clear_lockout(clear_lockout),
        .fault_n      (fault_n),
        .overcurrent_n(overcurrent_n),
        .gate_enable  (gate_enable),
        .precharge    (precharge),
        .pwm_allow    (pwm_allow),
        .state        (state),
        .retry_count  (retry_count),
        .lockout      (lockout),
        .fault_cause  (fault_cause)
    );

    // 10-unit clock period.
    always #5 pclk = ~pclk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Predicts the outputs after the coming clock edge from the inputs
    // applied for that edge.
    task automatic model_step(input bit r, input bit e, input bit c, input bit fn, input bit ocn);
        int nxt;
        bit fs, os, fq, oq, bad;
        if (r) begin
            m_state  = IDLE;
            m_age    = 0;
            m_retry  = 0;
            m_cause  = 0;
            m_streak = 0;
            f_pipe   = '{1'b1, 1'b1};
            o_pipe   = '{1'b1, 1'b1};
            return;
        end
        fs = f_pipe.pop_front();
        f_pipe.push_back(fn);
        os = o_pipe.pop_front();
        o_pipe.push_back(ocn);
        m_streak = os ? 0 : m_streak + 1;
        fq  = !fs;
        oq  = (m_streak >= F);
        bad = fq || oq;
        m_age++;
        nxt = m_state;
        case (m_state)
            IDLE: if (e && !bad) nxt = PRE;
            PRE: begin
                if (bad)             nxt = FLT;
                else if (!e)         nxt = IDLE;
                else if (m_age == P) nxt = RUN;
            end
            RUN: begin
                if (m_age >= C) m_retry = 0;
                if (bad)        nxt = FLT;
                else if (!e)    nxt = IDLE;
            end
            FLT: begin
                if (m_retry == MR) nxt = LOCK;
                else begin
                    m_retry++;
                    nxt = COOL;
                end
            end
            COOL: begin
                if (m_age == C) begin
                    if (!e)       nxt = IDLE;
                    else if (bad) m_age = 0;
                    else          nxt = PRE;
                end
            end
            LOCK: begin
                if (c) begin
                    nxt     = IDLE;
                    m_retry = 0;
                end
            end
            default: nxt = IDLE;
        endcase
        if (nxt == FLT) m_cause = m_cause | (oq ? 2 : 0) | (fq ? 1 : 0);
        else if (c)     m_cause = 0;
        if (nxt != m_state) m_age = 0;
        m_state = nxt;
    endtask

    // Drives one cycle of inputs on the falling edge, advances the model,
    // then returns just after the rising edge so the new outputs are visible.
    task automatic applyStimulus(input bit r, input bit e, input bit c, input bit fn, input bit ocn);
        @(negedge pclk);
        prst          = r;
        enable_req    = e;
        clear_lockout = c;
        fault_n       = fn;
        overcurrent_n = ocn;
        model_step(r, e, c, fn, ocn);
        checking = 1'b1;
        @(posedge pclk);
        #1;
    endtask

    // Runs clean cycles until the DUT reaches the target state or the budget expires.
    task automatic wait_state(input int target, input int limit, input string name);
        for (int i = 0; i < limit; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
            if (int'(state) == target) break;
        end
        checkOutput(name, int'(state), target);
    endtask

    // Every cycle, compare all outputs against the model between clock edges.
    always @(posedge pclk) begin
        #2;
        if (checking) begin
            checkOutput("m_state",   int'(state),       m_state);
            checkOutput("m_gate",    int'(gate_enable), int'(m_state == PRE || m_state == RUN));
            checkOutput("m_prech",   int'(precharge),   int'(m_state == PRE));
            checkOutput("m_pwm",     int'(pwm_allow),   int'(m_state == RUN));
            checkOutput("m_retry",   int'(retry_count), m_retry);
            checkOutput("m_lockout", int'(lockout),     int'(m_state == LOCK));
            checkOutput("m_cause",   int'(fault_cause), m_cause);
        end
    end

    // Guards against a stuck simulation.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios, then randomized traffic.
    initial begin
        bit en_l, f_l, o_l, r, c;

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("rst_state", int'(state), IDLE);
        checkOutput("rst_gate", int'(gate_enable), 0);
        checkOutput("rst_retry", int'(retry_count), 0);
        checkOutput("rst_lockout", int'(lockout), 0);
        checkOutput("rst_cause", int'(fault_cause), 0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("idle_hold", int'(state), IDLE);

        // Clean enable: 8 cycles of precharge, then run.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("pre_enter", int'(state), PRE);
        checkOutput("pre_gate", int'(gate_enable), 1);
        checkOutput("pre_prech", int'(precharge), 1);
        checkOutput("pre_pwm", int'(pwm_allow), 0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("pre_last", int'(state), PRE);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("run_enter", int'(state), RUN);
        checkOutput("run_pwm", int'(pwm_allow), 1);
        checkOutput("run_prech", int'(precharge), 0);

        // Overcurrent shorter than the filter is ignored; a full-length one faults.
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("oc_short", int'(state), RUN);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("oc_pending", int'(state), RUN);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("oc_fault", int'(state), FLT);
        checkOutput("oc_gate_off", int'(gate_enable), 0);
        checkOutput("oc_cause", int'(fault_cause), 2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("cool1_enter", int'(state), COOL);
        checkOutput("cool1_retry", int'(retry_count), 1);
        for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("cool1_last", int'(state), COOL);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("cool1_exit", int'(state), PRE);

        // Second and third faults in quick succession lead to lockout.
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("f2_state", int'(state), FLT);
        checkOutput("f2_cause", int'(fault_cause), 3);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("f2_retry", int'(retry_count), 2);
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("f2_restart", int'(state), PRE);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("f2_run", int'(state), RUN);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("f3_state", int'(state), FLT);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("lock_state", int'(state), LOCK);
        checkOutput("lock_flag", int'(lockout), 1);
        checkOutput("lock_retry", int'(retry_count), 2);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("lock_ignores_en", int'(state), LOCK);
        checkOutput("lock_gate", int'(gate_enable), 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("clr_state", int'(state), IDLE);
        checkOutput("clr_flag", int'(lockout), 0);
        checkOutput("clr_retry", int'(retry_count), 0);
        checkOutput("clr_cause", int'(fault_cause), 0);

        // Fault held through cooldown expiry restarts the count.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("hold_pre", int'(state), PRE);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("hold_fault", int'(state), FLT);
        checkOutput("hold_cause", int'(fault_cause), 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("hold_retry", int'(retry_count), 1);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("hold_restart", int'(state), COOL);
        wait_state(PRE, 40, "hold_release");

        // Fault outranks a simultaneous enable drop; reset mid-precharge.
        wait_state(RUN, 20, "prio_run");
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("prio_fault", int'(state), FLT);
        wait_state(PRE, 60, "prio_recover");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("prst_state", int'(state), IDLE);
        checkOutput("prst_gate", int'(gate_enable), 0);
        checkOutput("prst_prech", int'(precharge), 0);
        checkOutput("prst_retry", int'(retry_count), 0);

        // Randomized traffic with bursty fault and overcurrent levels.
        en_l = 1'b1;
        f_l  = 1'b1;
        o_l  = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(0, 199) == 0);
            c = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 99) < 2) en_l = ~en_l;
            if (f_l ? ($urandom_range(0, 99) < 2) : ($urandom_range(0, 99) < 40)) f_l = ~f_l;
            if (o_l ? ($urandom_range(0, 99) < 4) : ($urandom_range(0, 99) < 25)) o_l = ~o_l;
            applyStimulus(r, en_l, c, f_l, o_l);
        end

        #5;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
